// File: rtl/wb_manager.sv
// Classic Wishbone master: runs one arbitrated read/write per request,
// with a bounded ACK wait that ends in a one-cycle ERR state.
module wb_manager #(
    parameter int unsigned            ADDR_W   = 32,
    parameter int unsigned            DATA_W   = 32,
    parameter int unsigned            TIMEOUT  = 16,
    parameter logic [DATA_W-1:0]      ERR_DATA = 32'hBAD0BAD0
) (
    input  logic              clk,
    input  logic              Rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] adr_to_mem,
    input  logic [DATA_W-1:0] data_to_mem,
    input  logic [3:0]        sel_to_mem,
    output logic [DATA_W-1:0] data_from_mem,
    output logic              mem_busy,
    output logic              bus_err,
    output logic [ADDR_W-1:0] ADR_O,
    output logic [DATA_W-1:0] DAT_O,
    output logic [3:0]        SEL_O,
    output logic              WE_O,
    output logic              STB_O,
    output logic              CYC_O,
    input  logic [DATA_W-1:0] DAT_I,
    input  logic              ACK_I,
    input  logic              ERR_I
);

    localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUS, ERR} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [DATA_W-1:0] dat_q, dat_d;
    logic [3:0]        sel_q, sel_d;
    logic              we_q, we_d;
    logic              cyc_q, cyc_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    always_ff @(posedge clk) begin
        if (Rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            cyc_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            cyc_q   <= cyc_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        we_d    = we_q;
        cyc_d   = cyc_q;
        busy_d  = busy_q;
        err_d   = 1'b0;
        rdata_d = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (mem_read || mem_write) begin
                    state_d = BUS;
                    cnt_d   = '0;
                    adr_d   = adr_to_mem;
                    dat_d   = data_to_mem;
                    sel_d   = sel_to_mem;
                    we_d    = mem_write;
                    cyc_d   = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            BUS: begin
                // ERR_I beats ACK_I, but an ACK on the last allowed cycle still completes
                if (ERR_I) begin
                    state_d = ERR;
                    cyc_d   = 1'b0;
                    err_d   = 1'b1;
                    if (!we_q) rdata_d = ERR_DATA;
                end else if (ACK_I) begin
                    state_d = IDLE;
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                    busy_d  = 1'b0;
                    if (!we_q) rdata_d = DAT_I;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = ERR;
                    cyc_d   = 1'b0;
                    err_d   = 1'b1;
                    if (!we_q) rdata_d = ERR_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ERR: begin
                state_d = IDLE;
                we_d    = 1'b0;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    assign data_from_mem = rdata_q;
    assign mem_busy      = busy_q;
    assign bus_err       = err_q;
    assign ADR_O         = adr_q;
    assign DAT_O         = dat_q;
    assign SEL_O         = sel_q;
    assign WE_O          = we_q;
    assign STB_O         = cyc_q;
    assign CYC_O         = cyc_q;

endmodule

// File: tb/tb_wb_manager.sv
// Directed bench for wb_manager: read, write, write-wins, held request,
// timeout, ERR-over-ACK and mid-cycle reset.
module tb_wb_manager;

    logic        clk = 1'b0;
    logic        Rst;
    logic        mem_read, mem_write;
    logic [31:0] adr_to_mem, data_to_mem;
    logic [3:0]  sel_to_mem;
    logic [31:0] data_from_mem;
    logic        mem_busy, bus_err;
    logic [31:0] ADR_O, DAT_O;
    logic [3:0]  SEL_O;
    logic        WE_O, STB_O, CYC_O;
    logic [31:0] DAT_I;
    logic        ACK_I, ERR_I;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    wb_manager #(
        .ADDR_W(32), .DATA_W(32), .TIMEOUT(16), .ERR_DATA(32'hBAD0BAD0)
    ) dut (
        .clk(clk), .Rst(Rst),
        .mem_read(mem_read), .mem_write(mem_write),
        .adr_to_mem(adr_to_mem), .data_to_mem(data_to_mem), .sel_to_mem(sel_to_mem),
        .data_from_mem(data_from_mem), .mem_busy(mem_busy), .bus_err(bus_err),
        .ADR_O(ADR_O), .DAT_O(DAT_O), .SEL_O(SEL_O),
        .WE_O(WE_O), .STB_O(STB_O), .CYC_O(CYC_O),
        .DAT_I(DAT_I), .ACK_I(ACK_I), .ERR_I(ERR_I)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        Rst = 1'b1; mem_read = 1'b1; mem_write = 1'b0;
        adr_to_mem = 32'h000ABCDE; data_to_mem = '0; sel_to_mem = 4'b1111;
        DAT_I = '0; ACK_I = 1'b0; ERR_I = 1'b0;

        // reset with a read already requested
        tick(); tick();
        check("rst_cyc",  {31'd0, CYC_O}, 32'd0);
        check("rst_stb",  {31'd0, STB_O}, 32'd0);
        check("rst_busy", {31'd0, mem_busy}, 32'd0);
        check("rst_err",  {31'd0, bus_err}, 32'd0);
        check("rst_dfm",  data_from_mem, 32'd0);
        Rst = 1'b0;

        // read, ACK in third bus cycle
        tick();
        check("rd_cyc1", {31'd0, CYC_O}, 32'd1);
        check("rd_stb1", {31'd0, STB_O}, 32'd1);
        check("rd_busy", {31'd0, mem_busy}, 32'd1);
        check("rd_we",   {31'd0, WE_O}, 32'd0);
        check("rd_adr",  ADR_O, 32'h000ABCDE);
        mem_read = 1'b0; adr_to_mem = 32'hFFFF0000;
        tick();
        check("rd_cyc2",  {31'd0, CYC_O}, 32'd1);
        check("rd_adr_hold", ADR_O, 32'h000ABCDE);
        tick();
        check("rd_cyc3", {31'd0, CYC_O}, 32'd1);
        ACK_I = 1'b1; DAT_I = 32'h12345678;
        tick();
        ACK_I = 1'b0;
        check("rd_cyc_end",  {31'd0, CYC_O}, 32'd0);
        check("rd_busy_end", {31'd0, mem_busy}, 32'd0);
        check("rd_data",     data_from_mem, 32'h12345678);
        check("rd_noerr",    {31'd0, bus_err}, 32'd0);

        // write with immediate ACK
        mem_write = 1'b1; adr_to_mem = 32'h100; data_to_mem = 32'hDEADBEEF;
        sel_to_mem = 4'b0011; ACK_I = 1'b1; DAT_I = 32'h0BADF00D;
        tick();
        mem_write = 1'b0;
        check("wr_cyc", {31'd0, CYC_O}, 32'd1);
        check("wr_we",  {31'd0, WE_O}, 32'd1);
        check("wr_adr", ADR_O, 32'h100);
        check("wr_dat", DAT_O, 32'hDEADBEEF);
        check("wr_sel", {28'd0, SEL_O}, 32'h3);
        tick();
        check("wr_cyc_end", {31'd0, CYC_O}, 32'd0);
        check("wr_we_end",  {31'd0, WE_O}, 32'd0);
        check("wr_dfm",     data_from_mem, 32'h12345678);

        // read+write together, held: write wins, one idle cycle between accesses
        mem_read = 1'b1; mem_write = 1'b1; adr_to_mem = 32'h200;
        data_to_mem = 32'hA5A5A5A5; sel_to_mem = 4'b1111;
        tick();
        check("rw_we",  {31'd0, WE_O}, 32'd1);
        check("rw_cyc", {31'd0, CYC_O}, 32'd1);
        tick();
        check("rw_gap_cyc",  {31'd0, CYC_O}, 32'd0);
        check("rw_gap_busy", {31'd0, mem_busy}, 32'd0);
        check("rw_dfm",      data_from_mem, 32'h12345678);
        tick();
        check("rw_reissue", {31'd0, CYC_O}, 32'd1);
        mem_read = 1'b0; mem_write = 1'b0;
        tick();
        ACK_I = 1'b0;
        check("rw_done", {31'd0, CYC_O}, 32'd0);

        // timeout: 16 cycles with CYC high, then ERR
        mem_read = 1'b1; adr_to_mem = 32'h300;
        tick();
        mem_read = 1'b0;
        check("to_cyc1", {31'd0, CYC_O}, 32'd1);
        for (int i = 0; i < 15; i++) tick();
        check("to_cyc16", {31'd0, CYC_O}, 32'd1);
        tick();
        check("to_cyc_drop", {31'd0, CYC_O}, 32'd0);
        check("to_err",      {31'd0, bus_err}, 32'd1);
        check("to_busy",     {31'd0, mem_busy}, 32'd1);
        check("to_dfm",      data_from_mem, 32'hBAD0BAD0);
        tick();
        check("to_err_end",  {31'd0, bus_err}, 32'd0);
        check("to_busy_end", {31'd0, mem_busy}, 32'd0);

        // good read to move data_from_mem off ERR_DATA
        mem_read = 1'b1; adr_to_mem = 32'h350;
        tick();
        mem_read = 1'b0; ACK_I = 1'b1; DAT_I = 32'h0000CAFE;
        tick();
        ACK_I = 1'b0;
        check("rd2_data", data_from_mem, 32'h0000CAFE);

        // ERR_I and ACK_I together: error wins
        mem_read = 1'b1; adr_to_mem = 32'h400;
        tick();
        mem_read = 1'b0; ERR_I = 1'b1; ACK_I = 1'b1; DAT_I = 32'h11112222;
        tick();
        ERR_I = 1'b0; ACK_I = 1'b0;
        check("ea_err", {31'd0, bus_err}, 32'd1);
        check("ea_dfm", data_from_mem, 32'hBAD0BAD0);
        check("ea_cyc", {31'd0, CYC_O}, 32'd0);
        tick();
        check("ea_err_end", {31'd0, bus_err}, 32'd0);

        // reset in the middle of a bus cycle
        mem_read = 1'b1; adr_to_mem = 32'h500;
        tick();
        mem_read = 1'b0;
        check("mr_cyc", {31'd0, CYC_O}, 32'd1);
        tick();
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        check("mr_cyc0",  {31'd0, CYC_O}, 32'd0);
        check("mr_busy0", {31'd0, mem_busy}, 32'd0);
        check("mr_err0",  {31'd0, bus_err}, 32'd0);
        check("mr_adr0",  ADR_O, 32'd0);
        check("mr_dfm0",  data_from_mem, 32'd0);
        tick();
        check("mr_noerr", {31'd0, bus_err}, 32'd0);
        check("mr_idle",  {31'd0, CYC_O}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_manager.md
Name: wb_manager

Overview:
- Wishbone bus master directly downstream of the memory request handler.
- Takes the handler's single arbitrated request and runs it as one classic Wishbone read or write cycle.
- Returns read data and a busy indication to the handler.
- Bounds every bus cycle with a timeout so a missing slave cannot hang the VGA or the CPU.

Parameters:
- ADDR_W, 32, width of request and bus address.
- DATA_W, 32, width of data paths.
- TIMEOUT, 16, ACK_I wait cycles before the cycle is aborted (≥2).
- ERR_DATA, 32'hBAD0BAD0, value returned on a read that errors or times out.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- Rst  in  1  synchronous reset, active-high.
- mem_read  in  1  read request from the request handler.
- mem_write  in  1  write request from the request handler.
- adr_to_mem  in  ADDR_W  request byte address.
- data_to_mem  in  DATA_W  write data.
- sel_to_mem  in  4  byte-lane select.
- data_from_mem  out  DATA_W  read data back to the handler.
- mem_busy  out  1  a bus cycle is in progress.
- bus_err  out  1  one-cycle pulse: the last cycle ended in ERR_I or timeout.
- ADR_O  out  ADDR_W  Wishbone address.
- DAT_O  out  DATA_W  Wishbone write data.
- SEL_O  out  4  Wishbone select.
- WE_O  out  1  Wishbone write enable.
- STB_O  out  1  Wishbone strobe.
- CYC_O  out  1  Wishbone cycle.
- DAT_I  in  DATA_W  Wishbone read data.
- ACK_I  in  1  Wishbone acknowledge.
- ERR_I  in  1  Wishbone error.

Behaviour:
- Registered outputs; reset values: all outputs 0, data_from_mem 0, state IDLE, timeout counter 0.
- States: IDLE, BUS, ERR.
  - IDLE → BUS when (mem_read | mem_write) is sampled high at a clock edge.
  - BUS → IDLE on ACK_I.
  - BUS → ERR on ERR_I or timeout.
  - ERR → IDLE unconditionally after 1 cycle.
- Request capture (IDLE, request seen at edge E0):
  - Capture adr, data and sel into ADR_O/DAT_O/SEL_O.
  - WE_O = mem_write.
  - From E0, CYC_O = STB_O = mem_busy = 1.
  - If mem_read and mem_write are both high, the write wins (WE_O=1) and the read is dropped.
- BUS state:
  - ADR_O/DAT_O/SEL_O/WE_O hold constant; requester inputs are ignored.
  - The counter increments each cycle ACK_I=ERR_I=0.
- ACK_I sampled high at edge E1:
  - CYC_O/STB_O/WE_O/mem_busy drop to 0 from E1.
  - On a read, data_from_mem ← DAT_I at E1.
  - On a write, data_from_mem is unchanged.
  - Minimum bus latency is 1 cycle (ACK in the first BUS cycle).
- ERR_I and ACK_I both high: ERR_I takes priority.
- ERR_I high, or counter reaches TIMEOUT-1 with no ACK:
  - Drop CYC_O/STB_O; go to ERR.
  - On a read, data_from_mem ← ERR_DATA.
  - mem_busy stays 1 through the ERR cycle.
  - bus_err = 1 for exactly the ERR cycle.
- After returning to IDLE:
  - At least one cycle with mem_busy=0 and CYC_O=0 before the next capture.
  - A request held high is therefore re-issued no sooner than 1 idle cycle later; back-to-back throughput is ≥2 cycles per access.
- Counter clears on every capture.
- data_from_mem holds its last value until the next completed read.
- Rst mid-cycle: next edge forces IDLE, all outputs 0, CYC_O dropped immediately; the pending access is lost and there is no bus_err.
- ADR_O is passed through unmodified (byte address, no alignment check).

Test Plan:
- Reset: Rst=1 for 2 cycles with mem_read=1 → CYC_O=STB_O=mem_busy=bus_err=0, data_from_mem=0; first capture on the edge after Rst falls.
- Read, ACK after 3 cycles: mem_read=1, adr=32'h000ABCDE, sel=4'b1111 → ADR_O=32'h000ABCDE, WE_O=0, CYC_O/STB_O high 3 cycles; DAT_I=32'h12345678 with ACK → data_from_mem=32'h12345678, mem_busy low next cycle.
- Write, immediate ACK: mem_write=1, adr=32'h100, data=32'hDEADBEEF, sel=4'b0011 → DAT_O=32'hDEADBEEF, SEL_O=4'b0011, WE_O=1 for 1 cycle; data_from_mem unchanged.
- Simultaneous read+write, then held request: WE_O=1 on the first cycle; with the request held, CYC_O shows a 1-cycle gap between consecutive cycles.
- Timeout: read with ACK_I=0 forever → CYC_O drops after TIMEOUT=16 cycles; bus_err pulses 1 cycle; data_from_mem=32'hBAD0BAD0; then return to IDLE.
- ERR_I and ACK_I together on a read, and Rst asserted mid-BUS → ERR path taken (bus_err=1, ERR_DATA returned); on reset, all outputs 0 the next edge with no bus_err.
